// File: rtl/mult_div_unit_if.sv
// Bus bundle between the EX stage and the HI/LO multiply/divide unit.
// The pipeline side is the master. The unit is the slave.
interface mult_div_unit_if #(
   parameter int WIDTH = 32
) ();
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] rs_data;
   logic [WIDTH-1:0] rt_data;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;

   modport master (
      output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
      input  hi, lo, busy, done
   );

   modport slave (
      input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
      output hi, lo, busy, done
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit.
// MULT/MULTU use a shift-add multiply. DIV/DIVU use a restoring divide.
// Both run one bit per cycle on operand magnitudes. The sign is fixed up
// in a final cycle, and that same cycle writes HI/LO.
module mult_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic             clk,
   input logic             rst,
   mult_div_unit_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;

   stateT             state, stateNext;
   logic [CNT_W-1:0]  iterCount;
   logic [1:0]        opReg;
   logic              signA, signB;
   logic [WIDTH-1:0]  aRaw, opnd, accHi, accLo;
   logic [WIDTH-1:0]  hiReg, loReg;
   logic              doneReg;

   logic              accept, lastIter;
   logic              inSigned, inSignA, inSignB;
   logic [WIDTH-1:0]  inMagA, inMagB;
   logic [WIDTH:0]    mulSum, divTrial;
   logic [WIDTH-1:0]  divRem;
   logic              divGe;
   logic              negResult;
   logic [2*WIDTH-1:0] prodMag, prodFix;
   logic [WIDTH-1:0]  quotFix, remFix, resHi, resLo;

   // The FIX cycle also accepts a new start, so back-to-back ops lose no cycle.
   assign accept   = bus.start && (state == IDLE || state == FIX);
   assign lastIter = (iterCount == CNT_W'(WIDTH - 1));

   // State register. Reset discards any in-flight op.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   // Next state: IDLE -> RUN on start; RUN for WIDTH iterations; FIX for one cycle.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (accept) stateNext = RUN;
         RUN:     if (lastIter) stateNext = FIX;
         FIX:     stateNext = accept ? RUN : IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Operand magnitudes and signs. op[0] clear means a signed operation.
   always_comb begin
      inSigned = ~bus.op[0];
      inSignA  = inSigned & bus.rs_data[WIDTH-1];
      inSignB  = inSigned & bus.rt_data[WIDTH-1];
      inMagA   = inSignA ? -bus.rs_data : bus.rs_data;
      inMagB   = inSignB ? -bus.rt_data : bus.rt_data;
   end

   // One iteration step.
   // Multiply: accHi:accLo is the partial product, and accLo starts as the multiplier.
   // Divide: accHi is the partial remainder, and accLo shifts the dividend out and the quotient in.
   always_comb begin
      mulSum   = {1'b0, accHi} + {1'b0, (accLo[0] ? opnd : {WIDTH{1'b0}})};
      divTrial = {accHi, accLo[WIDTH-1]};
      divGe    = (divTrial >= {1'b0, opnd});
      divRem   = divTrial[WIDTH-1:0] - opnd;
   end

   // Sign fix-up and the final HI/LO values.
   // Divide by zero returns the raw dividend in HI and all ones in LO.
   always_comb begin
      negResult = ~opReg[0] & (signA ^ signB);
      prodMag   = {accHi, accLo};
      prodFix   = negResult ? -prodMag : prodMag;
      quotFix   = negResult ? -accLo : accLo;
      remFix    = (~opReg[0] & signA) ? -accHi : accHi;
      resHi     = prodFix[2*WIDTH-1:WIDTH];
      resLo     = prodFix[WIDTH-1:0];
      if (opReg[1]) begin
         if (opnd == {WIDTH{1'b0}}) begin
            resHi = aRaw;
            resLo = {WIDTH{1'b1}};
         end else begin
            resHi = remFix;
            resLo = quotFix;
         end
      end
   end

   // Datapath registers: load on an accepted start, then step once per RUN cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iterCount <= '0;
         opReg     <= '0;
         signA     <= 1'b0;
         signB     <= 1'b0;
         aRaw      <= '0;
         opnd      <= '0;
         accHi     <= '0;
         accLo     <= '0;
      end else if (accept) begin
         iterCount <= '0;
         opReg     <= bus.op;
         signA     <= inSignA;
         signB     <= inSignB;
         aRaw      <= bus.rs_data;
         opnd      <= inMagB;
         accHi     <= '0;
         accLo     <= inMagA;
      end else if (state == RUN) begin
         iterCount <= iterCount + CNT_W'(1);
         if (opReg[1]) begin
            accHi <= divGe ? divRem : divTrial[WIDTH-1:0];
            accLo <= {accLo[WIDTH-2:0], divGe};
         end else begin
            accHi <= mulSum[WIDTH:1];
            accLo <= {mulSum[0], accLo[WIDTH-1:1]};
         end
      end
   end

   // Architectural HI/LO. The FIX result wins. MTHI/MTLO act only in a true idle cycle with no start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hiReg <= '0;
         loReg <= '0;
      end else if (state == FIX) begin
         hiReg <= resHi;
         loReg <= resLo;
      end else if (state == IDLE && !bus.start) begin
         if (bus.hi_we) hiReg <= bus.wdata;
         if (bus.lo_we) loReg <= bus.wdata;
      end
   end

   // Done pulses for the one cycle after FIX writes HI/LO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) doneReg <= 1'b0;
      else     doneReg <= (state == FIX);
   end

   assign bus.hi   = hiReg;
   assign bus.lo   = loReg;
   assign bus.done = doneReg;
   // Busy drops in the done cycle, even when a back-to-back op has just been accepted.
   assign bus.busy = (state != IDLE) && !doneReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit.
// Expected values are hand-computed constants.
module tb_mult_div_unit;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mult_div_unit_if #(.WIDTH(32)) bus ();

   mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Issue one op and wait up to 40 edges for done.
   // lat is the edge index of done, or -1 on timeout.
   task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output int lat, output int busyBad, output int heldBad);
      logic [31:0] h0, l0;
      @(negedge clk);
      bus.start = 1'b1; bus.op = o; bus.rs_data = a; bus.rt_data = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      h0 = bus.hi; l0 = bus.lo;
      lat = -1; busyBad = 0; heldBad = 0;
      if (bus.busy !== 1'b1) busyBad++;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) begin
            lat = i;
            if (bus.busy !== 1'b0) busyBad++;
            break;
         end
         if (bus.busy !== 1'b1) busyBad++;
         if (bus.hi !== h0 || bus.lo !== l0) heldBad++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 0; bus.op = 0; bus.rs_data = 0; bus.rt_data = 0;
      bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 0", bus.hi); end
      checks++; if (bus.lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 0", bus.lo); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_mult();
      int lat, bb, hb;
      applyStimulus(2'b00, 32'hFFFFFFFD, 32'd5, lat, bb, hb);
      checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL mult_latency: got %0d expected 33", lat); end
      checks++; if (bb !== 0) begin errors++; $display("[TB] FAIL mult_busy_window: got %0d bad cycles expected 0", bb); end
      checks++; if (hb !== 0) begin errors++; $display("[TB] FAIL mult_hilo_held: got %0d changes expected 0", hb); end
      checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h expected ffffffff", bus.hi); end
      checks++; if (bus.lo !== 32'hFFFFFFF1) begin errors++; $display("[TB] FAIL mult_lo: got %h expected fffffff1", bus.lo); end
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL mult_done_pulse: got %b expected 0", bus.done); end
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b01; bus.rs_data = 32'hFFFFFFFF; bus.rt_data = 32'hFFFFFFFF;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (32) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b01; bus.rs_data = 32'd2; bus.rt_data = 32'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      checks++; if (bus.done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_done: got %b expected 1", bus.done); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_first_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.hi !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL multu_max_hi: got %h expected fffffffe", bus.hi); end
      checks++; if (bus.lo !== 32'h00000001) begin errors++; $display("[TB] FAIL multu_max_lo: got %h expected 00000001", bus.lo); end
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) begin lat = i; break; end
      end
      checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL b2b_second_latency: got %0d expected 33", lat); end
      checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL b2b_hi: got %h expected 0", bus.hi); end
      checks++; if (bus.lo !== 32'd6) begin errors++; $display("[TB] FAIL b2b_lo: got %h expected 6", bus.lo); end
   endtask

   task automatic test_divide();
      int lat, bb, hb;
      applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2, lat, bb, hb);
      checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL div_latency: got %0d expected 33", lat); end
      checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_neg_lo: got %h expected fffffffd", bus.lo); end
      checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div_neg_hi: got %h expected ffffffff", bus.hi); end
      applyStimulus(2'b11, 32'd100, 32'd7, lat, bb, hb);
      checks++; if (bb !== 0) begin errors++; $display("[TB] FAIL divu_busy_window: got %0d bad cycles expected 0", bb); end
      checks++; if (bus.lo !== 32'd14) begin errors++; $display("[TB] FAIL divu_lo: got %h expected 0000000e", bus.lo); end
      checks++; if (bus.hi !== 32'd2) begin errors++; $display("[TB] FAIL divu_hi: got %h expected 00000002", bus.hi); end
      applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, bb, hb);
      checks++; if (bus.lo !== 32'h80000000) begin errors++; $display("[TB] FAIL div_ovf_lo: got %h expected 80000000", bus.lo); end
      checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL div_ovf_hi: got %h expected 0", bus.hi); end
   endtask

   task automatic test_div_zero();
      int lat, bb, hb;
      applyStimulus(2'b11, 32'd7, 32'd0, lat, bb, hb);
      checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL divz_latency: got %0d expected 33", lat); end
      checks++; if (bus.hi !== 32'd7) begin errors++; $display("[TB] FAIL divz_hi: got %h expected 00000007", bus.hi); end
      checks++; if (bus.lo !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL divz_lo: got %h expected ffffffff", bus.lo); end
   endtask

   task automatic test_busy_ignore();
      int doneCnt, firstDone;
      logic [31:0] h, l;
      doneCnt = 0; firstDone = -1; h = '0; l = '0;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b11; bus.rs_data = 32'd9; bus.rt_data = 32'd2;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 1; i <= 45; i++) begin
         @(posedge clk); #1;
         bus.start = 1'b0; bus.lo_we = 1'b0;
         if (bus.done === 1'b1) begin
            doneCnt++;
            if (firstDone < 0) begin firstDone = i; h = bus.hi; l = bus.lo; end
         end
         if (i == 3) begin
            @(negedge clk);
            bus.start = 1'b1; bus.op = 2'b01; bus.rs_data = 32'd3; bus.rt_data = 32'd4;
            bus.lo_we = 1'b1; bus.wdata = 32'h55;
         end
      end
      checks++; if (doneCnt !== 1) begin errors++; $display("[TB] FAIL ignore_done_count: got %0d expected 1", doneCnt); end
      checks++; if (firstDone !== 33) begin errors++; $display("[TB] FAIL ignore_latency: got %0d expected 33", firstDone); end
      checks++; if (h !== 32'd1) begin errors++; $display("[TB] FAIL ignore_hi: got %h expected 00000001", h); end
      checks++; if (l !== 32'd4) begin errors++; $display("[TB] FAIL ignore_lo: got %h expected 00000004", l); end
      checks++; if (bus.lo !== 32'd4) begin errors++; $display("[TB] FAIL mtlo_busy_dropped: got %h expected 00000004", bus.lo); end
      @(negedge clk); bus.lo_we = 1'b1; bus.wdata = 32'h55;
      @(posedge clk); #1; bus.lo_we = 1'b0;
      checks++; if (bus.lo !== 32'h55) begin errors++; $display("[TB] FAIL mtlo_idle: got %h expected 00000055", bus.lo); end
      checks++; if (bus.hi !== 32'd1) begin errors++; $display("[TB] FAIL mtlo_hi_kept: got %h expected 00000001", bus.hi); end
      @(negedge clk); bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hA5A5A5A5;
      @(posedge clk); #1; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      checks++; if (bus.hi !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL mthi_both: got %h expected a5a5a5a5", bus.hi); end
      checks++; if (bus.lo !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL mtlo_both: got %h expected a5a5a5a5", bus.lo); end
   endtask

   task automatic test_reset_mid_op();
      int lat, bb, hb;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b00; bus.rs_data = 32'hFFFFFFFD; bus.rt_data = 32'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #3; rst = 1'b1; #1;
      checks++; if (bus.hi !== 32'h0) begin errors++; $display("[TB] FAIL async_rst_hi: got %h expected 0", bus.hi); end
      checks++; if (bus.lo !== 32'h0) begin errors++; $display("[TB] FAIL async_rst_lo: got %h expected 0", bus.lo); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_done: got %b expected 0", bus.done); end
      @(negedge clk); rst = 1'b0;
      applyStimulus(2'b00, 32'hFFFFFFFD, 32'd5, lat, bb, hb);
      checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL post_rst_latency: got %0d expected 33", lat); end
      checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL post_rst_hi: got %h expected ffffffff", bus.hi); end
      checks++; if (bus.lo !== 32'hFFFFFFF1) begin errors++; $display("[TB] FAIL post_rst_lo: got %h expected fffffff1", bus.lo); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_back_to_back();
      test_divide();
      test_div_zero();
      test_busy_ignore();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
